ce_frac_divider: RTL and testbench
==================================

Name: ce_frac_divider

Overview:
- Parametrised multi-channel clock-enable generator for the arcade top level.
- Replaces the ad hoc modulo counters: CPU enable (÷10), sound enable (÷41) and pixel enable.
- Each channel produces single-cycle enable pulses at a fractional rate num/den of clk_sys, using an accumulator.
- All channels run in one clock domain and support a global pause and a phase resync.

Parameters:
- NUM_CH, 3, number of independent enable channels.
- ACC_W, 16, width of the per-channel num, den and accumulator.

Ports:
- clk_sys  input  1  system clock; the only clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  global run; when low, all accumulators hold.
- sync  input  1  single-cycle phase restart of all channels.
- ch_en  input  NUM_CH  per-channel run enable.
- num  input  NUM_CH*ACC_W  per-channel numerator; channel i is in bits [i*ACC_W +: ACC_W].
- den  input  NUM_CH*ACC_W  per-channel denominator; same packing as num.
- ce_out  output  NUM_CH  enable pulses, registered.

Behaviour:
- Reset: sampled only on a rising clk_sys edge with reset_n=0.
  - All accumulators go to 0; ce_out goes to 0.
  - Reset overrides sync, enable and everything else.
- Per-channel step on a cycle where enable=1, ch_en[i]=1 and den[i]!=0:
  - sum = acc + num, computed at ACC_W+1 bits (no overflow).
  - If sum >= den: acc <= sum - den and ce_out[i] <= 1.
  - Otherwise: acc <= sum[ACC_W-1:0] and ce_out[i] <= 0.
- Latency: ce_out is asserted on the cycle after the accumulating edge.
- Rate: exactly num pulses every den cycles, with no cumulative drift.
- Boundary cases:
  - num=0: ce_out stays 0.
  - num>=den: ce_out=1 every cycle and acc is forced to 0. This saturates the rate at one pulse per cycle; there is never a double pulse.
  - den=0: the channel is treated as disabled; acc holds and ce_out=0.
- Pause: enable=0 or ch_en[i]=0 holds acc[i] and drives ce_out[i]=0 from the next cycle. Resuming continues from the held phase.
- Runtime change of num/den: the new values take effect on the next step. If the held acc >= the new den, acc is cleared to 0 and no pulse is emitted that cycle.
- sync=1, all channels on that edge:
  - acc <= 0 and ce_out <= 0.
  - Applies regardless of enable or ch_en.
  - The next step begins from phase 0, so channels with equal num/den produce coincident pulses.
- Simultaneous events: reset_n=0 wins over sync, and sync wins over enable and the step.
- Channels are fully independent; no arbitration between them.

Optional Feature:
- Macro: CE_FRAC_DIVIDER_HALF_PHASE_EN.
- When defined:
  - Adds output ce_half_out [NUM_CH].
  - ce_half_out[i] pulses for one cycle when acc crosses den/2 (den>>1) without wrapping, i.e. old acc < den>>1 and new acc >= den>>1.
  - It gives a falling-edge enable for two-phase CPU cores.
  - It follows the same latency, pause, sync and reset rules as ce_out and resets to 0.
  - When num>=den it stays 0.
- When not defined: the port and its logic are absent, and ce_out behaviour is unchanged.

Decomposition:
- Package ce_frac_pkg:
  - localparam DEFAULT_ACC_W=16.
  - typedef logic [DEFAULT_ACC_W-1:0] ce_ratio_t.
  - Named ratio constants: CE_DIV10 (num=1, den=10) and CE_DIV41 (num=1, den=41).
- Sub-module ce_frac_channel:
  - One accumulator with its compare/subtract logic and the optional half-phase detect.
  - The top module instantiates it NUM_CH times in a generate loop and slices num/den.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with enable=1 and num=1/den=10 → ce_out=0 throughout. After release, the first pulse appears 10 cycles after the first step and then repeats every 10 cycles.
- Fractional rate: ch1 num=3, den=8 for 800 cycles → exactly 300 pulses. Pulse spacing is only ever 2 or 3 cycles, and the pattern repeats every 8 cycles.
- Saturation and disable: ch0 num=12, den=10 → ce_out[0]=1 every cycle. ch2 den=0 → ce_out[2]=0 with acc held. ch2 num=0, den=5 → no pulses.
- Pause: drop enable for 7 cycles mid-period (acc=6, num=1, den=10) → no pulses during the pause. On resume, the next pulse arrives 4 steps later.
- Sync: channels 0 and 1 both num=1/den=41 but out of phase; pulse sync → both ce_out are low that cycle, then pulse together every 41 cycles. sync asserted together with reset_n=0 → reset behaviour only.
- Shrink den: acc=30 with den=41, then change den to 20 → acc clears with no pulse that cycle, and the next pulse arrives 20 cycles later. With CE_FRAC_DIVIDER_HALF_PHASE_EN and num=1/den=10 → ce_half_out pulses 5 cycles after each ce_out.

Source files
------------

// File: rtl/ce_frac_pkg.sv
// Shared types and ratio constants for the fractional clock-enable generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ce_frac_pkg;

  localparam int DEFAULT_ACC_W = 16;

  typedef logic [DEFAULT_ACC_W-1:0] ce_ratio_t;

  typedef struct packed {
    ce_ratio_t num;
    ce_ratio_t den;
  } ce_ratio_pair_t;

  // CPU enable: one pulse every 10 clk_sys cycles.
  localparam ce_ratio_pair_t CE_DIV10 = '{num: 16'd1, den: 16'd10};
  // Sound enable: one pulse every 41 clk_sys cycles.
  localparam ce_ratio_pair_t CE_DIV41 = '{num: 16'd1, den: 16'd41};

endpackage : ce_frac_pkg

// File: rtl/ce_frac_channel.sv
// One fractional-rate enable channel: accumulator, compare/subtract, optional half-phase detect.
// Latency: ce_out (and ce_half_out with CE_FRAC_DIVIDER_HALF_PHASE_EN) registered, 1 cycle after the accumulating edge.
// Backpressure: none; run=0 holds the phase and suppresses pulses, pulses are never queued.
module ce_frac_channel
  import ce_frac_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             run,
  input  logic             sync,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
  output logic             ce_half_out,
`endif
  output logic             ce_out
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             ce_nxt;
  logic [ACC_W:0]   sum;

  // One extra bit so acc + num can never wrap before the compare.
  assign sum = {1'b0, acc} + {1'b0, num};

`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
  logic [ACC_W-1:0] half_den;
  logic             half_nxt;
  assign half_den = den >> 1;
`endif

  // Next accumulator phase and pulse; sync beats the step, a stale phase is dropped silently.
  always_comb begin
    acc_nxt = acc;
    ce_nxt  = 1'b0;
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
    half_nxt = 1'b0;
`endif
    if (sync) begin
      acc_nxt = '0;
    end else if (run && (den != '0)) begin
      if (acc >= den) begin
        // den shrank below the held phase: restart without a pulse.
        acc_nxt = '0;
      end else if (num >= den) begin
        // Rate saturates at one pulse per cycle; keep the phase pinned at 0.
        acc_nxt = '0;
        ce_nxt  = 1'b1;
      end else if (sum >= {1'b0, den}) begin
        // True remainder is below den, so modulo-2^ACC_W subtraction is exact.
        acc_nxt = sum[ACC_W-1:0] - den;
        ce_nxt  = 1'b1;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
        half_nxt = (acc < half_den) && (sum[ACC_W-1:0] >= half_den);
`endif
      end
    end
  end

  // Phase and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc    <= '0;
      ce_out <= 1'b0;
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
      ce_half_out <= 1'b0;
`endif
    end else begin
      acc    <= acc_nxt;
      ce_out <= ce_nxt;
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
      ce_half_out <= half_nxt;
`endif
    end
  end

endmodule : ce_frac_channel

// File: rtl/ce_frac_divider.sv
// Multi-channel fractional clock-enable generator (num/den pulses per clk_sys); optional CE_FRAC_DIVIDER_HALF_PHASE_EN adds ce_half_out.
// Latency: every enable output is registered, 1 cycle after the accumulating edge.
// Backpressure: none; enable/ch_en low hold each channel's phase, sync restarts all channels at phase 0.
module ce_frac_divider
  import ce_frac_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*ACC_W-1:0] num,
  input  logic [NUM_CH*ACC_W-1:0] den,
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
  output logic [NUM_CH-1:0]       ce_half_out,
`endif
  output logic [NUM_CH-1:0]       ce_out
);

  // Independent channels; the global enable is folded into each channel's run.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_frac_channel #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .run         (enable & ch_en[g]),
      .sync        (sync),
      .num         (num[g*ACC_W +: ACC_W]),
      .den         (den[g*ACC_W +: ACC_W]),
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
      .ce_half_out (ce_half_out[g]),
`endif
      .ce_out      (ce_out[g])
    );
  end

endmodule : ce_frac_divider

// File: tb/tb_ce_frac_divider.sv
// Directed bench for ce_frac_divider: reset, fractional rate, saturation, pause, sync, den shrink.
// Latency: outputs sampled 1 time unit after each rising clk_sys edge.
// Backpressure: n/a.
module tb_ce_frac_divider;
  import ce_frac_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 16;

  logic                    clk_sys = 1'b0;
  logic                    reset_n;
  logic                    enable;
  logic                    sync;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*ACC_W-1:0] num;
  logic [NUM_CH*ACC_W-1:0] den;
  logic [NUM_CH-1:0]       ce_out;
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
  logic [NUM_CH-1:0]       ce_half_out;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  bit hist [800];

  ce_frac_divider #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .enable      (enable),
    .sync        (sync),
    .ch_en       (ch_en),
    .num         (num),
    .den         (den),
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
    .ce_half_out (ce_half_out),
`endif
    .ce_out      (ce_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_ch(input int ch, input int n, input int d);
    num[ch*ACC_W +: ACC_W] = n[ACC_W-1:0];
    den[ch*ACC_W +: ACC_W] = d[ACC_W-1:0];
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  // Count pulses per channel over n cycles.
  task automatic run_cnt(input int n, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (ce_out[0]) c0++;
      if (ce_out[1]) c1++;
      if (ce_out[2]) c2++;
    end
  endtask

  // Cycles until the next pulse (sel 0: ce_out, 1: ce_half_out); -1 if none within lim.
  task automatic wait_ce(input int ch, input int sel, input int lim, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      tick();
      n++;
      if (sel == 0) hit = ce_out[ch];
`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
      else hit = ce_half_out[ch];
`endif
    end
    if (!hit) n = -1;
  endtask

  initial begin
    int c0, c1, c2, n, last, min_sp, max_sp, pat_err, both;

    reset_n = 1'b0;
    enable  = 1'b1;
    sync    = 1'b0;
    ch_en   = '1;
    num     = '0;
    den     = '0;
    set_ch(0, int'(CE_DIV10.num), int'(CE_DIV10.den));

    // Reset held for 3 cycles: no pulses.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_ce", int'(ce_out), 0);
    end
    reset_n = 1'b1;

    // 1/10 after reset: pulse on steps 10, 20, 30 only.
    c0 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ce_out[0] != (k % 10 == 0)) c0++;
    end
    chk("div10_pattern_errs", c0, 0);

    // 3/8 on ch1 for 800 cycles.
    set_ch(1, 3, 8);
    c0 = 0; c1 = 0; last = -1; min_sp = 999; max_sp = 0; pat_err = 0;
    for (int k = 0; k < 800; k++) begin
      tick();
      hist[k] = ce_out[1];
      if (ce_out[0]) c0++;
      if (ce_out[1]) begin
        c1++;
        if (last >= 0) begin
          if (k - last < min_sp) min_sp = k - last;
          if (k - last > max_sp) max_sp = k - last;
        end
        last = k;
      end
      if (k >= 8 && hist[k] != hist[k-8]) pat_err++;
    end
    chk("frac_3_8_count", c1, 300);
    chk("frac_min_spacing", min_sp, 2);
    chk("frac_max_spacing", max_sp, 3);
    chk("frac_period8_errs", pat_err, 0);
    chk("div10_800_count", c0, 80);

    // Saturation on ch0, den=0 hold on ch2.
    set_ch(0, 12, 10);
    set_ch(2, 1, 10);
    run_cnt(3, c0, c1, c2);
    chk("sat_first3", c0, 3);
    set_ch(2, 1, 0);
    run_cnt(20, c0, c1, c2);
    chk("sat_every_cycle", c0, 20);
    chk("den0_no_pulse", c2, 0);
    set_ch(2, 1, 10);
    wait_ce(2, 0, 20, n);
    chk("den0_phase_held", n, 7);
    set_ch(2, 0, 5);
    run_cnt(20, c0, c1, c2);
    chk("num0_no_pulse", c2, 0);

    // Pause: sync, step to acc=6, drop enable 7 cycles, resume.
    set_ch(0, 1, 10);
    pulse_sync();
    chk("sync_clears_sat", int'(ce_out), 0);
    run_cnt(6, c0, c1, c2);
    chk("pre_pause_ch0", c0, 0);
    enable = 1'b0;
    run_cnt(7, c0, c1, c2);
    chk("pause_all_quiet", c0 + c1 + c2, 0);
    enable = 1'b1;
    wait_ce(0, 0, 20, n);
    chk("resume_4_steps", n, 4);
    ch_en = 3'b110;
    run_cnt(5, c0, c1, c2);
    chk("ch_en_pause", c0, 0);
    ch_en = 3'b111;
    wait_ce(0, 0, 20, n);
    chk("ch_en_resume", n, 10);

    // Sync: two 1/41 channels 10 cycles out of phase, then realigned.
    set_ch(0, 1, 41);
    set_ch(1, 1, 41);
    pulse_sync();
    ch_en = 3'b101;
    run_cnt(10, c0, c1, c2);
    ch_en = 3'b111;
    c0 = 0; c1 = 0; both = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (ce_out[0]) c0++;
      if (ce_out[1]) c1++;
      if (ce_out[0] && ce_out[1]) both++;
    end
    chk("oop_ch0_count", c0, 1);
    chk("oop_ch1_count", c1, 1);
    chk("oop_coincident", both, 0);
    pulse_sync();
    chk("sync_cycle_low", int'(ce_out[1:0]), 0);
    wait_ce(0, 0, 60, n);
    chk("sync_first_41", n, 41);
    chk("sync_ch1_together", int'(ce_out[1]), 1);
    wait_ce(0, 0, 60, n);
    chk("sync_second_41", n, 41);
    chk("sync_ch1_together2", int'(ce_out[1]), 1);

    // Sync together with reset: reset wins, channels restart from 0.
    set_ch(0, 12, 10);
    run_cnt(2, c0, c1, c2);
    chk("sat_before_rst", c0, 2);
    sync = 1'b1;
    reset_n = 1'b0;
    tick();
    chk("rst_sync_ce", int'(ce_out), 0);
    sync = 1'b0;
    reset_n = 1'b1;
    set_ch(0, 1, 10);
    wait_ce(0, 0, 20, n);
    chk("after_rst_first", n, 10);

    // Shrink den below the held phase.
    set_ch(0, 1, 41);
    pulse_sync();
    run_cnt(30, c0, c1, c2);
    chk("pre_shrink_quiet", c0, 0);
    set_ch(0, 1, 20);
    tick();
    chk("shrink_no_pulse", int'(ce_out[0]), 0);
    wait_ce(0, 0, 40, n);
    chk("shrink_next_20", n, 20);

`ifdef CE_FRAC_DIVIDER_HALF_PHASE_EN
    // Half phase: 1/10 gives ce_half_out 5 cycles after each ce_out.
    set_ch(0, 1, 10);
    pulse_sync();
    wait_ce(0, 0, 20, n);
    chk("half_ce_first", n, 10);
    wait_ce(0, 1, 20, n);
    chk("half_after_ce", n, 5);
    wait_ce(0, 0, 20, n);
    chk("ce_after_half", n, 5);
    set_ch(0, 12, 10);
    c0 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ce_half_out[0]) c0++;
    end
    chk("half_sat_quiet", c0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_ce_frac_divider
